// File: rtl/conv1d_pkg.sv
// Shared types and width helpers for the streaming conv1d layer.
package conv1d_pkg;

  localparam int DEF_BW = 8;

  typedef enum logic [1:0] {FILL, ACCEPT, COMPUTE} state_e;

  function automatic int bias_bw(input int bw);
    return 4 * bw;
  endfunction

  function automatic int acc_bw(input int bw);
    return 4 * bw;
  endfunction

  function automatic int bank_w(input int fl);
    return $clog2(fl + 1);
  endfunction

  function automatic int addr_w(input int nf);
    return (nf > 1) ? $clog2(nf) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv1d_dot.sv
// Window x filter dot product plus bias, registered with a stall enable.
module conv1d_dot #(
  parameter int COLUMN_LEN = 13,
  parameter int FILTER_LEN = 3,
  parameter int BW         = 8,
  parameter int AB         = 32
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  input  logic                                          en_i,
  input  logic [FILTER_LEN-1:0][COLUMN_LEN-1:0][BW-1:0] x_i,
  input  logic [FILTER_LEN-1:0][COLUMN_LEN-1:0][BW-1:0] w_i,
  input  logic [AB-1:0]                                 bias_i,
  output logic signed [AB-1:0]                          acc_o
);

  localparam int N = FILTER_LEN * COLUMN_LEN;

  logic signed [AB-1:0] prod [N];
  logic signed [AB-1:0] sum;

  for (genvar t = 0; t < FILTER_LEN; t++) begin : g_tap
    for (genvar e = 0; e < COLUMN_LEN; e++) begin : g_elem
      logic signed [2*BW-1:0] p;
      assign p = signed'(x_i[t][e]) * signed'(w_i[t][e]);
      assign prod[t*COLUMN_LEN+e] = AB'(p);
    end
  end

  always_comb begin
    sum = signed'(bias_i);
    for (int i = 0; i < N; i++) sum = sum + prod[i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  acc_o <= '0;
    else if (en_i) acc_o <= sum;
  end

endmodule

// File: rtl/conv1d_tdm.sv
// Streaming 1D conv layer: sliding frame window, one filter issued per cycle,
// ReLU + requantise to BW, full valid/ready backpressure.
module conv1d_tdm
  import conv1d_pkg::*;
#(
  parameter int FRAME_LEN   = 50,
  parameter int COLUMN_LEN  = 13,
  parameter int NUM_FILTERS = 8,
  parameter int FILTER_LEN  = 3,
  parameter int BW          = DEF_BW,
  parameter int QUANT_SHIFT = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [COLUMN_LEN*BW-1:0]          data_i,
  input  logic                              valid_i,
  input  logic                              last_i,
  output logic                              ready_o,
  output logic [BW-1:0]                     data_o,
  output logic                              valid_o,
  output logic                              last_o,
  input  logic                              ready_i,
  output logic                              idle_o,
  input  logic                              rd_en_i,
  input  logic                              wr_en_i,
  input  logic [bank_w(FILTER_LEN)-1:0]     rd_wr_bank_i,
  input  logic [addr_w(NUM_FILTERS)-1:0]    rd_wr_addr_i,
  input  logic [COLUMN_LEN*BW-1:0]          wr_data_i,
  output logic [COLUMN_LEN*BW-1:0]          rd_data_o
);

  localparam int CW  = COLUMN_LEN * BW;
  localparam int BB  = bias_bw(BW);
  localparam int AB  = acc_bw(BW);
  localparam int FW  = addr_w(NUM_FILTERS);
  localparam int KW  = bank_w(FILTER_LEN);
  localparam int NW  = cnt_w(FRAME_LEN);
  localparam int LW  = cnt_w(FILTER_LEN);
  localparam logic [AB-1:0] QMAX = AB'((1 << (BW - 1)) - 1);

  logic [CW-1:0] w_mem [NUM_FILTERS][FILTER_LEN];
  logic [BB-1:0] b_mem [NUM_FILTERS];

  logic [FILTER_LEN-1:0][CW-1:0] win, w_sel;
  state_e               state;
  logic [LW-1:0]        fill_cnt;
  logic [NW-1:0]        frame_cnt;
  logic [FW-1:0]        f;
  logic                 win_last, stall, accept, last_eff, issue_vld, issue_lst, f_end, addr_ok;
  logic [2:1]           vld_pipe, lst_pipe;
  logic signed [AB-1:0] acc;
  logic [AB-1:0]        relu, q;
  logic [BW-1:0]        q_sat;

  assign stall     = valid_o & ~ready_i;
  assign ready_o   = rst_n_i & (state != COMPUTE);
  assign accept    = valid_i & ready_o;
  // a full-length sequence without last_i is closed by the frame counter
  assign last_eff  = last_i | (frame_cnt == NW'(FRAME_LEN - 1));
  assign issue_vld = (state == COMPUTE);
  assign f_end     = (f == FW'(NUM_FILTERS - 1));
  assign issue_lst = win_last & f_end;
  assign idle_o    = (state != COMPUTE) & ~|vld_pipe;
  assign valid_o   = vld_pipe[2];
  assign last_o    = lst_pipe[2];
  assign addr_ok   = {1'b0, rd_wr_addr_i} < (FW + 1)'(NUM_FILTERS);

  always_comb begin
    w_sel = '0;
    for (int t = 0; t < FILTER_LEN; t++) w_sel[t] = w_mem[f][t];
  end

  conv1d_dot #(.COLUMN_LEN(COLUMN_LEN), .FILTER_LEN(FILTER_LEN), .BW(BW), .AB(AB)) u_dot (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (issue_vld & ~stall),
    .x_i    (win),
    .w_i    (w_sel),
    .bias_i (b_mem[f]),
    .acc_o  (acc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= FILL;
      win       <= '0;
      fill_cnt  <= '0;
      frame_cnt <= '0;
      f         <= '0;
      win_last  <= 1'b0;
    end else begin
      if (accept) begin
        win       <= {data_i, win[FILTER_LEN-1:1]};
        frame_cnt <= last_eff ? '0 : frame_cnt + 1'b1;
        win_last  <= last_eff;
      end
      case (state)
        FILL: if (accept) begin
          if (fill_cnt == LW'(FILTER_LEN - 1)) begin
            state    <= COMPUTE;
            fill_cnt <= '0;
          end else if (last_eff) begin
            win      <= '0;
            fill_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        ACCEPT: if (accept) state <= COMPUTE;
        COMPUTE: if (!stall) begin
          f <= f_end ? '0 : f + 1'b1;
          if (f_end) begin
            state <= win_last ? FILL : ACCEPT;
            if (win_last) win <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    relu  = acc[AB-1] ? '0 : acc;
    q     = relu >> QUANT_SHIFT;
    q_sat = (q > QMAX) ? QMAX[BW-1:0] : q[BW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      data_o   <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[1], issue_vld};
      lst_pipe <= {lst_pipe[1], issue_lst};
      if (vld_pipe[1]) data_o <= q_sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && addr_ok) begin
      if (rd_wr_bank_i < KW'(FILTER_LEN))       w_mem[rd_wr_addr_i][rd_wr_bank_i] <= wr_data_i;
      else if (rd_wr_bank_i == KW'(FILTER_LEN)) b_mem[rd_wr_addr_i] <= wr_data_i[BB-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      if (!addr_ok)                             rd_data_o <= '0;
      else if (rd_wr_bank_i < KW'(FILTER_LEN))  rd_data_o <= w_mem[rd_wr_addr_i][rd_wr_bank_i];
      else if (rd_wr_bank_i == KW'(FILTER_LEN)) rd_data_o <= CW'(signed'(b_mem[rd_wr_addr_i]));
      else                                      rd_data_o <= '0;
    end
  end

  cfg_idle_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                               (rd_en_i || wr_en_i) |-> idle_o);

endmodule

// File: tb/tb_conv1d_tdm.sv
// Scoreboard bench for conv1d_tdm: behavioural conv model feeds an expected queue.
module tb_conv1d_tdm;

  localparam int FRAME_LEN = 50, COLUMN_LEN = 13, NUM_FILTERS = 8, FILTER_LEN = 3;
  localparam int BW = 8, QUANT_SHIFT = 8, CW = COLUMN_LEN * BW;

  logic          clk_i = 1'b0, rst_n_i = 1'b0;
  logic [CW-1:0] data_i = '0, wr_data_i = '0;
  logic          valid_i = 1'b0, last_i = 1'b0, ready_i = 1'b1;
  logic          rd_en_i = 1'b0, wr_en_i = 1'b0;
  logic [1:0]    rd_wr_bank_i = '0;
  logic [2:0]    rd_wr_addr_i = '0;
  logic          ready_o, valid_o, last_o, idle_o;
  logic [BW-1:0] data_o;
  logic [CW-1:0] rd_data_o;

  conv1d_tdm #(.FRAME_LEN(FRAME_LEN), .COLUMN_LEN(COLUMN_LEN), .NUM_FILTERS(NUM_FILTERS),
               .FILTER_LEN(FILTER_LEN), .BW(BW), .QUANT_SHIFT(QUANT_SHIFT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i),
    .idle_o(idle_o), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i), .rd_wr_bank_i(rd_wr_bank_i),
    .rd_wr_addr_i(rd_wr_addr_i), .wr_data_i(wr_data_i), .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int d; bit l; } exp_t;
  exp_t sb[$];
  int   errs = 0, checks = 0, out_cnt = 0;
  bit   rnd_ready = 1'b0;

  logic [CW-1:0] wv [NUM_FILTERS][FILTER_LEN];
  logic [31:0]   bv [NUM_FILTERS];
  int            mw [FILTER_LEN][COLUMN_LEN];
  int            mfill = 0, mfcnt = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int elem(input logic [CW-1:0] v, input int e);
    logic signed [BW-1:0] s;
    s = v[e*BW +: BW];
    return int'(s);
  endfunction

  function automatic logic [CW-1:0] rnd_vec(input int lo, input int hi);
    logic [CW-1:0] v;
    for (int e = 0; e < COLUMN_LEN; e++) v[e*BW +: BW] = BW'(int'($urandom_range(0, hi - lo)) + lo);
    return v;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < FILTER_LEN; t++)
      for (int e = 0; e < COLUMN_LEN; e++) mw[t][e] = 0;
    mfill = 0;
    mfcnt = 0;
  endtask

  // Reference: slide window, on a full window push one result per filter.
  task automatic model_frame(input logic [CW-1:0] x, input bit last);
    bit le;
    longint acc;
    for (int t = 0; t < FILTER_LEN - 1; t++)
      for (int e = 0; e < COLUMN_LEN; e++) mw[t][e] = mw[t+1][e];
    for (int e = 0; e < COLUMN_LEN; e++) mw[FILTER_LEN-1][e] = elem(x, e);
    mfcnt++;
    le = last || (mfcnt == FRAME_LEN);
    if (mfill < FILTER_LEN) mfill++;
    if (mfill == FILTER_LEN) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        acc = longint'($signed(bv[f]));
        for (int t = 0; t < FILTER_LEN; t++)
          for (int e = 0; e < COLUMN_LEN; e++) acc += elem(wv[f][t], e) * mw[t][e];
        if (acc < 0) acc = 0;
        acc = acc >>> QUANT_SHIFT;
        if (acc > 127) acc = 127;
        sb.push_back('{d: int'(acc), l: le && (f == NUM_FILTERS - 1)});
      end
    end
    if (le) model_clear();
  endtask

  task automatic send_frame(input logic [CW-1:0] x, input bit last);
    bit done = 1'b0;
    model_frame(x, last);
    data_i = x; last_i = last; valid_i = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_i); done = ready_o;
      @(posedge clk_i); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic cfg_wr(input int bank, input int addr, input logic [CW-1:0] d);
    wr_en_i = 1'b1; rd_wr_bank_i = 2'(bank); rd_wr_addr_i = 3'(addr); wr_data_i = d;
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
    if (bank < FILTER_LEN) wv[addr][bank] = d;
    else                   bv[addr] = d[31:0];
  endtask

  task automatic cfg_rd(input string tag, input int bank, input int addr, input logic [CW-1:0] exp);
    rd_en_i = 1'b1; rd_wr_bank_i = 2'(bank); rd_wr_addr_i = 3'(addr);
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    chk(tag, rd_data_o, exp);
  endtask

  // mode 0: tap1 elem0=64, bias f*256; 1: all 127; 2: zero weights, bias -1000/+512; 3: random
  task automatic load_cfg(input int mode);
    logic [CW-1:0] d;
    int b;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int t = 0; t < FILTER_LEN; t++) begin
        case (mode)
          0:       d = (t == 1) ? CW'(64) : '0;
          1:       d = {COLUMN_LEN{8'd127}};
          3:       d = rnd_vec(-16, 16);
          default: d = '0;
        endcase
        cfg_wr(t, f, d);
      end
      case (mode)
        0:       b = f * 256;
        1:       b = 0;
        2:       b = (f % 2 == 0) ? -1000 : 512;
        default: b = int'($urandom_range(0, 4000)) - 2000;
      endcase
      cfg_wr(FILTER_LEN, f, CW'(b));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(idle_o && sb.size() == 0) && n < 8000) begin
      @(posedge clk_i); #1; n++;
    end
    chk("drain_timeout", 32'(n < 8000), 1);
  endtask

  always @(posedge clk_i) begin
    #1;
    ready_i = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  bit            pst = 1'b0;
  logic [BW-1:0] pd;
  logic          pl;
  exp_t          sbe;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      pst = 1'b0;
    end else begin
      if (pst) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_data", data_o, pd);
        chk("stall_last", last_o, pl);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          sbe = sb.pop_front();
          chk("out_data", data_o, BW'(sbe.d));
          chk("out_last", last_o, sbe.l);
        end
        out_cnt++;
      end
      pst = valid_o && !ready_i; pd = data_o; pl = last_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] ex;
    model_clear();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_ready", ready_o, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("fill_ready", ready_o, 1);

    // time ramp through the middle tap, filter-dependent bias offset
    load_cfg(0);
    cfg_rd("rd_w_tap1", 1, 3, CW'(64));
    cfg_rd("rd_bias_pos", FILTER_LEN, 3, CW'(768));
    for (int t = 0; t < 5; t++) send_frame(CW'(4 * t), t == 4);
    wait_idle();

    // saturation
    load_cfg(1);
    for (int t = 0; t < 3; t++) send_frame({COLUMN_LEN{8'd127}}, t == 2);
    wait_idle();

    // ReLU floor and positive bias
    load_cfg(2);
    ex = '1; ex[31:0] = 32'hFFFF_FC18;
    cfg_rd("rd_bias_neg", FILTER_LEN, 0, ex);
    for (int t = 0; t < 3; t++) send_frame(rnd_vec(-128, 127), t == 2);
    wait_idle();

    // too-short sequence, then a minimal one
    load_cfg(3);
    for (int t = 0; t < 2; t++) send_frame(rnd_vec(-64, 63), t == 1);
    wait_idle();
    out_cnt = 0;
    for (int t = 0; t < 3; t++) send_frame(rnd_vec(-64, 63), t == 2);
    wait_idle();
    chk("short_then_min_count", out_cnt, NUM_FILTERS);

    // frame-counter close with random backpressure
    rnd_ready = 1'b1;
    for (int t = 0; t < FRAME_LEN; t++) send_frame(rnd_vec(-64, 63), 1'b0);
    wait_idle();
    rnd_ready = 1'b0;
    @(posedge clk_i); #1;

    // asynchronous reset while filter 4 is issuing
    for (int t = 0; t < 3; t++) send_frame(rnd_vec(-64, 63), 1'b0);
    chk("ready_in_compute", ready_o, 0);
    repeat (4) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_last", last_o, 0);
    chk("arst_ready", ready_o, 0);
    chk("arst_idle", idle_o, 1);
    sb.delete();
    model_clear();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_ready", ready_o, 1);
    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int t = 0; t < FILTER_LEN; t++) cfg_rd("rd_keep_w", t, f, wv[f][t]);
      ex = {{(CW-32){bv[f][31]}}, bv[f]};
      cfg_rd("rd_keep_b", FILTER_LEN, f, ex);
    end
    out_cnt = 0;
    for (int t = 0; t < 3; t++) send_frame(rnd_vec(-64, 63), t == 2);
    wait_idle();
    chk("post_rst_count", out_cnt, NUM_FILTERS);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
